mu0_phase_sequencer: RTL and testbench

//  Generates the MU0 instruction-cycle phases FETCH/EXEC1/EXEC2 that drive the control decoder.

---
 rtl/mu0_phase_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_mu0_phase_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_phase_sequencer.sv
// ---------------------------------------------------------------------------
// mu0_phase_sequencer
//
// Purpose:
//   Generates the MU0 instruction-cycle phases (FETCH / EXEC1 / EXEC2) that
//   drive the control decoder. It latches the instruction word from program
//   memory into the IR and chooses the next phase from the IR opcode. It also
//   handles memory-ready stalls, stops on STP, flags illegal opcodes and
//   counts issued instructions. It sits between program memory and the
//   control decoder.
//
// Parameters:
//   CNT_W     width of o_instr_count
//   IR_RESET  IR contents after reset
//
// Ports:
//   i_clk          system clock; all state changes on the rising edge
//   i_rst          synchronous, active-high reset
//   i_run          start request, only looked at while idle
//   i_mem_rdy      i_mem_q holds a valid instruction word this cycle
//   i_mem_q        instruction word from program memory
//   i_step         single-step request (only with MU0_SINGLE_STEP_EN)
//   o_fetch        fetch phase
//   o_exec1        execute phase 1
//   o_exec2        execute phase 2 (LDA/ADD/SUB only)
//   o_op           IR[15:12], opcode to the decoder
//   o_operand      IR[11:0], address/immediate
//   o_ir_load      IR captures i_mem_q at the coming edge
//   o_halted       STP executed; core stopped until reset
//   o_illegal      sticky flag: opcode B..F reached EXEC1
//   o_instr_count  saturating count of instructions entering EXEC1
//
// Configuration:
//   MU0_SINGLE_STEP_EN  when defined, adds i_step. Each rising edge of
//                       i_step lets exactly one instruction leave FETCH.
// ---------------------------------------------------------------------------
module mu0_phase_sequencer #(
    parameter int          CNT_W    = 16,
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_mem_rdy,
    input  logic [15:0]      i_mem_q,
`ifdef MU0_SINGLE_STEP_EN
    input  logic             i_step,
`endif
    output logic             o_fetch,
    output logic             o_exec1,
    output logic             o_exec2,
    output logic [3:0]       o_op,
    output logic [11:0]      o_operand,
    output logic             o_ir_load,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_FIRST_ILLEGAL = 4'hB;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_ir;
    logic              r_fetch;
    logic              r_exec1;
    logic              r_exec2;
    logic              r_halted;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_instr_count;

    logic [3:0]        w_op;
    logic              w_op_long;
    logic              w_op_stp;
    logic              w_op_illegal;
    logic              w_step_ok;
    logic              w_advance;

    assign w_op         = r_ir[15:12];
    assign w_op_long    = (w_op == OP_LDA) || (w_op == OP_ADD) || (w_op == OP_SUB);
    assign w_op_stp     = (w_op == OP_STP);
    assign w_op_illegal = (w_op >= OP_FIRST_ILLEGAL);

`ifdef MU0_SINGLE_STEP_EN
    // Single-step gate: a rising edge of i_step arms r_step_req, and the
    // FETCH advance consumes it. An edge arriving in the very cycle of the
    // advance wins over the clear so that step is not lost.
    logic r_step_d;
    logic r_step_req;
    logic w_step_edge;

    assign w_step_edge = i_step & ~r_step_d;
    assign w_step_ok   = r_step_req;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step_d   <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_step_d <= i_step;
            if (w_step_edge) begin
                r_step_req <= 1'b1;
            end else if (w_advance) begin
                r_step_req <= 1'b0;
            end
        end
    end
`else
    assign w_step_ok = 1'b1;
`endif

    // A fetch completes (and the IR loads) only when memory has the word and,
    // in single-step builds, a step has been requested.
    assign w_advance = r_fetch & i_mem_rdy & w_step_ok;

    // Next-phase selection. EXEC1 branches on the opcode held in the IR;
    // illegal opcodes simply return to FETCH like a NOP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_advance) begin
                    w_next_state = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (w_op_stp) begin
                    w_next_state = S_HALT;
                end else if (w_op_long) begin
                    w_next_state = S_EXEC2;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXEC2: begin
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Phase register. The phase outputs are registered copies decoded from
    // the next state so they line up with r_state without extra logic depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_fetch  <= 1'b0;
            r_exec1  <= 1'b0;
            r_exec2  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_fetch  <= (w_next_state == S_FETCH);
            r_exec1  <= (w_next_state == S_EXEC1);
            r_exec2  <= (w_next_state == S_EXEC2);
            r_halted <= (w_next_state == S_HALT);
        end
    end

    // Instruction register: holds its value through stalls and through the
    // execute phases until the next completed fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ir <= IR_RESET;
        end else if (w_advance) begin
            r_ir <= i_mem_q;
        end
    end

    // Issued-instruction counter, saturating at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr_count <= '0;
        end else if (w_advance && (r_instr_count != CNT_MAX)) begin
            r_instr_count <= r_instr_count + CNT_ONE;
        end
    end

    // Sticky illegal-opcode flag; it rises on the edge that leaves EXEC1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_EXEC1) && w_op_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    assign o_fetch       = r_fetch;
    assign o_exec1       = r_exec1;
    assign o_exec2       = r_exec2;
    assign o_halted      = r_halted;
    assign o_illegal     = r_illegal;
    assign o_instr_count = r_instr_count;
    assign o_op          = r_ir[15:12];
    assign o_operand     = r_ir[11:0];
    assign o_ir_load     = w_advance;

endmodule

// File: tb/tb_mu0_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mu0_phase_sequencer
//
// Directed vector table for the documented instruction sequences, a halt
// soak with random RUN/MEM_RDY, and a long random run compared against an
// instruction-level model. Single-step builds get a dedicated step sequence.
// ---------------------------------------------------------------------------
module tb_mu0_phase_sequencer;

    localparam int          CNT_W    = 4;
    localparam logic [15:0] IR_RESET = 16'h3ABC;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    localparam byte PH_E1   = 8'd1;
    localparam byte PH_E2   = 8'd2;
    localparam byte PH_HALT = 8'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             rdy;
    logic [15:0]      q;
    logic             step;
    logic             fetch;
    logic             exec1;
    logic             exec2;
    logic [3:0]       op;
    logic [11:0]      operand;
    logic             irLoad;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    mu0_phase_sequencer #(
        .CNT_W    (CNT_W),
        .IR_RESET (IR_RESET)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_run         (run),
        .i_mem_rdy     (rdy),
        .i_mem_q       (q),
`ifdef MU0_SINGLE_STEP_EN
        .i_step        (step),
`endif
        .o_fetch       (fetch),
        .o_exec1       (exec1),
        .o_exec2       (exec2),
        .o_op          (op),
        .o_operand     (operand),
        .o_ir_load     (irLoad),
        .o_halted      (halted),
        .o_illegal     (illegal),
        .o_instr_count (count)
    );

    always #5 clk = ~clk;

    // Instruction-level model: once started, an empty phase list means the
    // core is fetching; a completed fetch appends the execute phases the
    // instruction needs (and a terminal halt marker for STP).
    bit          mStarted;
    byte         mPhases[$];
    logic [15:0] mIr;
    int          mCount;
    bit          mIllegal;

    task automatic modelStep();
        if (rst) begin
            mStarted = 0;
            mPhases.delete();
            mIr      = IR_RESET;
            mCount   = 0;
            mIllegal = 0;
        end else if (!mStarted) begin
            if (run) mStarted = 1;
        end else if (mPhases.size() == 0) begin
            if (rdy) begin
                mIr = q;
                if (mCount < CNT_MAX) mCount = mCount + 1;
                mPhases.push_back(PH_E1);
                if (q[15:12] == 4'h0 || q[15:12] == 4'h2 || q[15:12] == 4'h3)
                    mPhases.push_back(PH_E2);
                if (q[15:12] == 4'h7)
                    mPhases.push_back(PH_HALT);
            end
        end else if (mPhases[0] != PH_HALT) begin
            if (mPhases[0] == PH_E1 && mIr[15:12] >= 4'hB) mIllegal = 1;
            void'(mPhases.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ru, input logic rd,
                                 input logic [15:0] qq);
        rst = r;
        run = ru;
        rdy = rd;
        q   = qq;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkAgainstModel();
        bit expFetch;
        bit expE1;
        bit expE2;
        bit expHalt;
        expFetch = mStarted && (mPhases.size() == 0);
        expE1    = (mPhases.size() > 0) && (mPhases[0] == PH_E1);
        expE2    = (mPhases.size() > 0) && (mPhases[0] == PH_E2);
        expHalt  = (mPhases.size() > 0) && (mPhases[0] == PH_HALT);
        checkOutput("rnd_fetch",   32'(fetch),   32'(expFetch));
        checkOutput("rnd_exec1",   32'(exec1),   32'(expE1));
        checkOutput("rnd_exec2",   32'(exec2),   32'(expE2));
        checkOutput("rnd_halted",  32'(halted),  32'(expHalt));
        checkOutput("rnd_illegal", 32'(illegal), 32'(mIllegal));
        checkOutput("rnd_ir",      32'({op, operand}), 32'(mIr));
        checkOutput("rnd_count",   32'(count),   32'(mCount));
        checkOutput("rnd_irload",  32'(irLoad),  32'(expFetch & rdy));
    endtask

    typedef struct {
        logic        rst;
        logic        run;
        logic        rdy;
        logic [15:0] q;
        logic        f;
        logic        e1;
        logic        e2;
        logic        h;
        logic        il;
        logic        ld;
        logic [15:0] ir;
        int          cnt;
    } vec_t;

    function automatic vec_t mkVec(logic r, logic ru, logic rd, logic [15:0] qq,
                                   logic f, logic e1, logic e2, logic h, logic il,
                                   logic ld, logic [15:0] ir, int cnt);
        vec_t v;
        v.rst = r;  v.run = ru; v.rdy = rd; v.q = qq;
        v.f = f;    v.e1 = e1;  v.e2 = e2;  v.h = h;
        v.il = il;  v.ld = ld;  v.ir = ir;  v.cnt = cnt;
        return v;
    endfunction

    task automatic runDirected();
        vec_t vecs[19];
        //                 rst run rdy q         f  e1 e2 h  il ld ir        cnt
        vecs[0]  = mkVec(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, IR_RESET, 0);
        vecs[1]  = mkVec(1, 1, 1, 16'h0005, 0, 0, 0, 0, 0, 0, IR_RESET, 0);
        vecs[2]  = mkVec(0, 1, 1, 16'h0005, 1, 0, 0, 0, 0, 1, IR_RESET, 0);
        vecs[3]  = mkVec(0, 0, 1, 16'h0005, 0, 1, 0, 0, 0, 0, 16'h0005, 1);
        vecs[4]  = mkVec(0, 1, 1, 16'h1010, 0, 0, 1, 0, 0, 0, 16'h0005, 1);
        vecs[5]  = mkVec(0, 0, 1, 16'h1010, 1, 0, 0, 0, 0, 1, 16'h0005, 1);
        vecs[6]  = mkVec(0, 0, 1, 16'h1010, 0, 1, 0, 0, 0, 0, 16'h1010, 2);
        vecs[7]  = mkVec(0, 0, 1, 16'h8042, 1, 0, 0, 0, 0, 1, 16'h1010, 2);
        vecs[8]  = mkVec(0, 0, 1, 16'h8042, 0, 1, 0, 0, 0, 0, 16'h8042, 3);
        vecs[9]  = mkVec(0, 0, 1, 16'hF123, 1, 0, 0, 0, 0, 1, 16'h8042, 3);
        vecs[10] = mkVec(0, 0, 1, 16'hF123, 0, 1, 0, 0, 0, 0, 16'hF123, 4);
        vecs[11] = mkVec(0, 0, 0, 16'h7000, 1, 0, 0, 0, 1, 0, 16'hF123, 4);
        vecs[12] = mkVec(0, 0, 0, 16'h7000, 1, 0, 0, 0, 1, 0, 16'hF123, 4);
        vecs[13] = mkVec(0, 0, 0, 16'h7000, 1, 0, 0, 0, 1, 0, 16'hF123, 4);
        vecs[14] = mkVec(0, 0, 0, 16'h7000, 1, 0, 0, 0, 1, 0, 16'hF123, 4);
        vecs[15] = mkVec(0, 0, 1, 16'h7000, 0, 1, 0, 0, 1, 0, 16'h7000, 5);
        vecs[16] = mkVec(0, 1, 1, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h7000, 5);
        vecs[17] = mkVec(1, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 0, IR_RESET, 0);
        vecs[18] = mkVec(0, 0, 1, 16'h1234, 0, 0, 0, 0, 0, 0, IR_RESET, 0);

        for (int i = 0; i < 19; i++) begin
            if (i == 17) begin
                // Halt must absorb any RUN/MEM_RDY activity until reset.
                for (int k = 0; k < 22; k++) begin
                    applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), 16'($urandom));
                    checkOutput("halt_halted", 32'(halted), 32'd1);
                    checkOutput("halt_phases", 32'({fetch, exec1, exec2}), 32'd0);
                    checkOutput("halt_count",  32'(count), 32'd5);
                    checkOutput("halt_irload", 32'(irLoad), 32'd0);
                    checkOutput("halt_ir",     32'({op, operand}), 32'h7000);
                end
            end
            applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].rdy, vecs[i].q);
            checkOutput($sformatf("vec%0d_fetch", i),   32'(fetch),   32'(vecs[i].f));
            checkOutput($sformatf("vec%0d_exec1", i),   32'(exec1),   32'(vecs[i].e1));
            checkOutput($sformatf("vec%0d_exec2", i),   32'(exec2),   32'(vecs[i].e2));
            checkOutput($sformatf("vec%0d_halted", i),  32'(halted),  32'(vecs[i].h));
            checkOutput($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].il));
            checkOutput($sformatf("vec%0d_irload", i),  32'(irLoad),  32'(vecs[i].ld));
            checkOutput($sformatf("vec%0d_ir", i),      32'({op, operand}), 32'(vecs[i].ir));
            checkOutput($sformatf("vec%0d_count", i),   32'(count),   32'(vecs[i].cnt));
        end
    endtask

    task automatic runRandom();
        logic        r;
        logic [3:0]  rop;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkAgainstModel();
        for (int n = 0; n < 4000; n++) begin
            if (mPhases.size() > 0 && mPhases[0] == PH_HALT)
                r = ($urandom_range(0, 15) == 0);
            else
                r = ($urandom_range(0, 299) == 0);
            rop = 4'($urandom_range(0, 15));
            if (rop == 4'h7 && $urandom_range(0, 9) != 0) rop = 4'h2;
            applyStimulus(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                          {rop, 12'($urandom)});
            checkAgainstModel();
        end
    endtask

    task automatic runStepTest();
        step = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("step_rst_fetch", 32'(fetch), 32'd0);
        checkOutput("step_rst_count", 32'(count), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1010);
        checkOutput("step_enter_fetch", 32'(fetch), 32'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h1010);
            checkOutput("step_stall_fetch", 32'(fetch), 32'd1);
            checkOutput("step_stall_count", 32'(count), 32'd0);
            checkOutput("step_stall_irload", 32'(irLoad), 32'd0);
        end
        step = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1010);
        checkOutput("step_armed_fetch", 32'(fetch), 32'd1);
        checkOutput("step_armed_irload", 32'(irLoad), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1010);
        checkOutput("step_exec1", 32'(exec1), 32'd1);
        checkOutput("step_count1", 32'(count), 32'd1);
        checkOutput("step_ir", 32'({op, operand}), 32'h1010);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h8042);
            checkOutput("step_held_fetch", 32'(fetch), 32'd1);
            checkOutput("step_held_count", 32'(count), 32'd1);
        end
        step = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h8042);
        checkOutput("step_low_count", 32'(count), 32'd1);
        step = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h8042);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h8042);
        checkOutput("step_second_exec1", 32'(exec1), 32'd1);
        checkOutput("step_second_count", 32'(count), 32'd2);
    endtask

    initial begin
        rst  = 1'b1;
        run  = 1'b0;
        rdy  = 1'b0;
        q    = 16'h0000;
        step = 1'b0;
        mStarted = 0;
        mIr      = IR_RESET;
        mCount   = 0;
        mIllegal = 0;
        @(posedge clk);
        #1;
`ifdef MU0_SINGLE_STEP_EN
        runStepTest();
`else
        runDirected();
        runRandom();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
